// File: rtl/nco_sched_pkg.sv
// Shared types and default sizing for the NCO slot scheduler.
package nco_sched_pkg;
  localparam int VOICES_D   = 8;
  localparam int V_OSC_D    = 4;
  localparam int V_WIDTH_D  = 3;
  localparam int O_WIDTH_D  = 2;
  localparam int SLOT_DIV_D = 4;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Phase-RAM address pair at default widths.
  typedef struct packed {
    logic [V_WIDTH_D-1:0] vx;
    logic [O_WIDTH_D-1:0] ox;
  } slot_idx_t;
endpackage

// File: rtl/nco_slot_sched_if.sv
// Control/slot-address bundle between the scheduler and the NCO datapath.
interface nco_slot_sched_if import nco_sched_pkg::*; #(
  parameter int VOICES  = VOICES_D,
  parameter int V_WIDTH = V_WIDTH_D,
  parameter int O_WIDTH = O_WIDTH_D
);
  logic               run;
  logic [VOICES-1:0]  reset_req;
  logic [VOICES-1:0]  reset_ack;
  logic [V_WIDTH-1:0] vx;
  logic [O_WIDTH-1:0] ox;
  logic               osc_accum_zero;
  logic               slot_clk;
  logic               slot_stb;
  logic               frame_stb;

  modport master (
    output run, reset_req,
    input  reset_ack, vx, ox, osc_accum_zero, slot_clk, slot_stb, frame_stb
  );
  modport slave (
    input  run, reset_req,
    output reset_ack, vx, ox, osc_accum_zero, slot_clk, slot_stb, frame_stb
  );
endinterface

// File: rtl/nco_slot_div.sv
// Slot divider: position within a slot, slot clock and slot-start strobe.
module nco_slot_div #(
  parameter int SLOT_DIV = 4
) (
  input  logic OSC_CLK,
  input  logic iRST_N,
  input  logic start,
  input  logic run_en,
  output logic slot_clk,
  output logic slot_stb,
  output logic pre_last,
  output logic last
);
  localparam int DW = $clog2(SLOT_DIV);

  logic [DW-1:0] div_cnt;

  assign last     = run_en && (div_cnt == DW'(SLOT_DIV-1));
  assign pre_last = run_en && (div_cnt == DW'(SLOT_DIV-2));

  // start loads the first cycle of a slot; anything else outside a slot parks at zero.
  always_ff @(posedge OSC_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      div_cnt  <= '0;
      slot_clk <= 1'b0;
      slot_stb <= 1'b0;
    end else if (start) begin
      div_cnt  <= '0;
      slot_clk <= 1'b1;
      slot_stb <= 1'b1;
    end else if (run_en && !last) begin
      div_cnt  <= div_cnt + 1'b1;
      slot_clk <= (div_cnt < DW'(SLOT_DIV/2 - 1));
      slot_stb <= 1'b0;
    end else begin
      div_cnt  <= '0;
      slot_clk <= 1'b0;
      slot_stb <= 1'b0;
    end
  end
endmodule

// File: rtl/nco_slot_sched.sv
// NCO bank slot scheduler: sweeps {vx,ox}, and zeroes whole voices on request
// within a single frame before acknowledging.
module nco_slot_sched import nco_sched_pkg::*; #(
  parameter int VOICES   = VOICES_D,
  parameter int V_OSC    = V_OSC_D,
  parameter int V_WIDTH  = V_WIDTH_D,
  parameter int O_WIDTH  = O_WIDTH_D,
  parameter int SLOT_DIV = SLOT_DIV_D
) (
  input logic             OSC_CLK,
  input logic             iRST_N,
  nco_slot_sched_if.slave bus
);
  typedef struct packed {
    logic [V_WIDTH-1:0] vx;
    logic [O_WIDTH-1:0] ox;
  } idx_t;

  state_t            state_q, state_d;
  idx_t              idx_q, idx_nx;
  logic              start, stop, last, pre_last, tail, run_en;
  logic              zero_q, frame_q;
  logic [VOICES-1:0] pend_q, arm_q, pend_nx, arm_nx;
  logic [VOICES-1:0] load_vec, ack_vec, ack_q, req_all;

  assign run_en  = (state_q == RUN);
  assign req_all = pend_q | bus.reset_req;

  nco_slot_div #(.SLOT_DIV(SLOT_DIV)) u_div (
    .OSC_CLK (OSC_CLK),
    .iRST_N  (iRST_N),
    .start   (start),
    .run_en  (run_en),
    .slot_clk(bus.slot_clk),
    .slot_stb(bus.slot_stb),
    .pre_last(pre_last),
    .last    (last)
  );

  always_ff @(posedge OSC_CLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Leaving RUN only happens on a slot boundary so the running slot completes.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    stop    = 1'b0;
    case (state_q)
      IDLE: if (bus.run) begin
        state_d = RUN;
        start   = 1'b1;
      end
      RUN: if (last) begin
        if (bus.run) start = 1'b1;
        else begin
          state_d = IDLE;
          stop    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_nx = '0;
    if (run_en) begin
      idx_nx = idx_q;
      if (idx_q.ox == O_WIDTH'(V_OSC-1)) begin
        idx_nx.ox = '0;
        idx_nx.vx = (idx_q.vx == V_WIDTH'(VOICES-1)) ? '0 : idx_q.vx + 1'b1;
      end else begin
        idx_nx.ox = idx_q.ox + 1'b1;
      end
    end
  end

  // tail: the edge into the last cycle of a voice's final oscillator slot.
  assign tail     = run_en && pre_last && (idx_q.ox == O_WIDTH'(V_OSC-1));
  assign load_vec = (start && idx_nx.ox == '0) ? (VOICES'(1) << idx_nx.vx) : '0;
  assign ack_vec  = tail ? (arm_q & (VOICES'(1) << idx_q.vx)) : '0;

  // On stop an armed voice falls back to pending so its zero is redone in full.
  always_comb begin
    if (stop) begin
      pend_nx = req_all | arm_q;
      arm_nx  = '0;
    end else begin
      pend_nx = req_all & ~load_vec;
      arm_nx  = (arm_q & ~ack_vec & ~load_vec) | (load_vec & req_all);
    end
  end

  always_ff @(posedge OSC_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pend_q  <= '0;
      arm_q   <= '0;
      ack_q   <= '0;
      frame_q <= 1'b0;
      idx_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      pend_q  <= pend_nx;
      arm_q   <= arm_nx;
      ack_q   <= ack_vec;
      frame_q <= tail && (idx_q.vx == V_WIDTH'(VOICES-1));
      if (start) begin
        idx_q  <= idx_nx;
        zero_q <= arm_nx[idx_nx.vx];
      end else if (stop) begin
        idx_q  <= '0;
        zero_q <= 1'b0;
      end
    end
  end

  assign bus.vx             = idx_q.vx;
  assign bus.ox             = idx_q.ox;
  assign bus.osc_accum_zero = zero_q;
  assign bus.reset_ack      = ack_q;
  assign bus.frame_stb      = frame_q;
endmodule

// File: tb/tb_nco_slot_sched.sv
// Directed bench for nco_slot_sched at default parameters.
module tb_nco_slot_sched;
  import nco_sched_pkg::*;

  logic OSC_CLK = 1'b0;
  logic iRST_N  = 1'b0;
  int   nchk = 0, npass = 0;
  int   fr, ns, nc, lf, ls, lc;
  logic [7:0] zcur, znext;

  always #5 OSC_CLK = ~OSC_CLK;

  nco_slot_sched_if #(.VOICES(8), .V_WIDTH(3), .O_WIDTH(2)) bus();

  nco_slot_sched #(.VOICES(8), .V_OSC(4), .V_WIDTH(3), .O_WIDTH(2), .SLOT_DIV(4)) dut (
    .OSC_CLK(OSC_CLK),
    .iRST_N (iRST_N),
    .bus    (bus)
  );

  function automatic logic [16:0] obs();
    return {bus.vx, bus.ox, bus.slot_stb, bus.slot_clk, bus.frame_stb,
            bus.osc_accum_zero, bus.reset_ack};
  endfunction

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] want);
    nchk++;
    assert (got === want) npass++;
    else $error("FAIL %s f=%0d s=%0d c=%0d got=%h want=%h", tag, lf, ls, lc, got, want);
  endtask

  // One running cycle: expected word from slot position and this frame's zero mask.
  task automatic cyc();
    slot_idx_t   ei;
    logic [16:0] e;
    int          v, o;
    @(posedge OSC_CLK); #1;
    bus.reset_req = '0;
    v = ns / 4;
    o = ns % 4;
    ei.vx = v[2:0];
    ei.ox = o[1:0];
    e = {ei, (nc == 0), (nc < 2), (ns == 31 && nc == 3), zcur[v], 8'h00};
    if (zcur[v] && o == 3 && nc == 3) e[v] = 1'b1;
    lf = fr; ls = ns; lc = nc;
    chk("cyc", obs(), e);
    nc++;
    if (nc == 4) begin
      nc = 0;
      ns++;
      if (ns == 32) begin
        ns = 0;
        fr++;
        zcur = znext;
        znext = '0;
      end
    end
  endtask

  task automatic idle_cyc();
    @(posedge OSC_CLK); #1;
    bus.reset_req = '0;
    chk("idle", obs(), '0);
  endtask

  task automatic run_to(input int f, input int s, input int c);
    for (int k = 0; k < 600; k++) begin
      if (lf == f && ls == s && lc == c) break;
      cyc();
    end
  endtask

  task automatic restart(input int f, input logic [7:0] z);
    fr = f; ns = 0; nc = 0; zcur = z; znext = '0;
  endtask

  initial begin
    bus.run = 1'b0;
    bus.reset_req = '0;
    lf = -1; ls = 0; lc = 0;
    restart(0, 8'h00);
    #12;
    chk("rst", obs(), '0);
    @(posedge OSC_CLK); #1;
    iRST_N = 1'b1;
    repeat (3) idle_cyc();

    // Frame 0: clean sweep.
    bus.run = 1'b1;
    run_to(0, 31, 3);
    // Frame 1: request for voice 2 during slot (1,0) lands this frame.
    run_to(1, 4, 1);  bus.reset_req[2] = 1'b1; zcur[2] = 1'b1;
    // Frame 2: request during slot (2,1) waits for frame 3.
    run_to(2, 9, 1);  bus.reset_req[2] = 1'b1; znext[2] = 1'b1;
    // Frame 3: three merged requests for voice 5, last one just before (5,0).
    run_to(3, 1, 1);  bus.reset_req[5] = 1'b1; zcur[5] = 1'b1;
    run_to(3, 14, 2); bus.reset_req[5] = 1'b1;
    run_to(3, 19, 3); bus.reset_req[5] = 1'b1;
    // Frame 4: request in the (0,0) start cycle defers; voice 3 armed then run dropped.
    run_to(4, 0, 0);  bus.reset_req[0] = 1'b1; znext[0] = 1'b1;
    run_to(4, 5, 1);  bus.reset_req[3] = 1'b1; zcur[3] = 1'b1;
    run_to(4, 14, 1); bus.run = 1'b0;
    cyc();
    cyc();
    repeat (5) idle_cyc();
    // Restart: voices 0 and 3 are zeroed in full, then reset with voice 6 pending.
    bus.run = 1'b1;
    restart(5, znext | 8'h08);
    run_to(5, 17, 1); bus.reset_req[6] = 1'b1;
    run_to(5, 21, 1);
    iRST_N = 1'b0;
    #2;
    chk("arst", obs(), '0);
    @(posedge OSC_CLK); #1;
    chk("rst_hold", obs(), '0);
    iRST_N = 1'b1;
    restart(6, 8'h00);
    run_to(6, 31, 3);
    run_to(7, 3, 3);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
